vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_TOT, default 800, total pixels per line.
REQ-005 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_TOT 525, with the same meanings in lines.
REQ-006 SHALL have parameter CLK_DIV, default 4, system clocks per pixel (≥1).
REQ-007 SHALL have parameter COLOR_SIZE, default 12, pixel colour width.
REQ-008 iClk  in  1  system clock; one clock domain, all state on its rising edge.
REQ-009 iRst_n  in  1  reset, asynchronous assert, active-low.
REQ-010 oCountH  out  $clog2(H_TOT)  current pixel column, fed to the pattern modules.
REQ-011 oCountV  out  $clog2(V_TOT)  current line, fed to the pattern modules.
REQ-012 oPixTick  out  1  one-clock strobe marking each pixel advance.
REQ-013 oFrameStart  out  1  one-clock strobe when the counters enter (0,0).
REQ-014 iDraw  in  1  combined draw flag from the pattern modules for (oCountH,oCountV).
REQ-015 iColor  in  COLOR_SIZE  colour from the pattern modules for (oCountH,oCountV).
REQ-016 oHS, oVS  out  1 each  sync outputs, active-low.
REQ-017 oColor  out  COLOR_SIZE  registered, blanked pixel colour.

Function
REQ-018 A prescaler 0..CLK_DIV-1 SHALL free-run; oPixTick SHALL be 1 in the clock where the prescaler equals CLK_DIV-1, else 0.
REQ-019 On oPixTick, oCountH SHALL increment, wrapping H_TOT-1 -> 0.
REQ-020 On oPixTick with oCountH = H_TOT-1, oCountV SHALL increment, wrapping V_TOT-1 -> 0. No other event SHALL change oCountV.
REQ-021 oFrameStart SHALL pulse in the clock after the counters change from (H_TOT-1, V_TOT-1) to (0,0). It SHALL also pulse once at the first oPixTick after reset.
REQ-022 Active region SHALL be oCountH < H_ACTIVE and oCountV < V_ACTIVE.
REQ-023 HS-low region SHALL be H_ACTIVE+H_FP ≤ oCountH < H_ACTIVE+H_FP+H_SYNC (656..751 at defaults).
REQ-024 VS-low region SHALL be V_ACTIVE+V_FP ≤ oCountV < V_ACTIVE+V_FP+V_SYNC (490..491 at defaults).
REQ-025 Output pipeline, one pixel stage: on each oPixTick, the block SHALL register oHS, oVS and oColor from the counter values held before the increment.
REQ-026 oColor SHALL be iColor when the registered position is active and iDraw=1, else 0 (black); it SHALL be 0 throughout blanking.
REQ-027 oHS, oVS and oColor SHALL change only on oPixTick clocks; they SHALL lag oCountH/oCountV by exactly one pixel period.
REQ-028 iDraw and iColor SHALL be sampled only in oPixTick clocks; values at other times SHALL have no effect.
REQ-029 Counter arithmetic SHALL be unsigned at the port widths; no counter SHALL ever exceed H_TOT-1 or V_TOT-1.

Reset
REQ-030 While iRst_n=0, the block SHALL hold: prescaler 0, oCountH 0, oCountV 0, oPixTick 0, oFrameStart 0, oHS 1, oVS 1, oColor 0.
REQ-031 Assertion of reset mid-frame SHALL take effect immediately, without waiting for iClk.
REQ-032 After deassertion, the first oPixTick SHALL occur on the CLK_DIV-th rising edge.

Structure
REQ-033 The default 640x480@60 timing constants SHALL live in a shared package (vga_timing_pkg), reused by the pattern modules for H_TOT, V_TOT and COLOR_SIZE.
REQ-034 The prescaler SHALL be a separate sub-module, pix_tick_gen (parameter CLK_DIV, output a strobe); the counters, decode and output register SHALL stay in vga_timing_gen.

Verification
REQ-035 Reset release with defaults -> oPixTick high on clocks 4, 8, 12...; after 4 pixel ticks, oCountH=4, oCountV=0, oHS=oVS=1, oColor=0.
REQ-036 Run to oCountH=799, oCountV=0, then one tick -> oCountH=0, oCountV=1; at (799,524), one tick -> (0,0) and a single oFrameStart pulse; pulses 1,680,000 clocks apart.
REQ-037 Line scan -> oHS low for exactly 96 ticks, first low while oCountH=657, high again while oCountH=753; frame scan -> oVS low for exactly 1600 ticks (lines 490-491, delayed one pixel).
REQ-038 iDraw=1, iColor=12'h630 constant -> oColor=12'h630 for 640x480 pixels per frame, and 0 at every blanking pixel, including oCountH 640..799 and oCountV ≥480.
REQ-039 Assert iRst_n=0 asynchronously at (320,240) between edges -> all outputs take their reset values before the next edge; after release, the frame restarts at (0,0) with oFrameStart.
REQ-040 Parameter override CLK_DIV=1, H_TOT=10, H_ACTIVE=4, H_FP=1, H_SYNC=2, V_TOT=5, V_ACTIVE=2, V_FP=1, V_SYNC=1 -> tick every clock, frame period 50 clocks, HS low at registered H 5..6.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared 640x480@60 timing constants and small helpers. The timing
//   generator and the pattern modules both take their H_TOT, V_TOT and
//   COLOR_SIZE defaults from here, so the counter widths match on both sides.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    // Horizontal timing, in pixels
    localparam int unsigned DEF_H_ACTIVE   = 640;
    localparam int unsigned DEF_H_FP       = 16;
    localparam int unsigned DEF_H_SYNC     = 96;
    localparam int unsigned DEF_H_TOT      = 800;

    // Vertical timing, in lines
    localparam int unsigned DEF_V_ACTIVE   = 480;
    localparam int unsigned DEF_V_FP       = 10;
    localparam int unsigned DEF_V_SYNC     = 2;
    localparam int unsigned DEF_V_TOT      = 525;

    // System clocks per pixel and colour width
    localparam int unsigned DEF_CLK_DIV    = 4;
    localparam int unsigned DEF_COLOR_SIZE = 12;

    // Counter widths derived from the default totals, for pattern modules
    localparam int unsigned DEF_H_W = $clog2(DEF_H_TOT);
    localparam int unsigned DEF_V_W = $clog2(DEF_V_TOT);

    // True when lo <= pos < lo + len. Positions are zero-extended to 32 bits
    // by the caller so every comparison is unsigned.
    function automatic logic in_window(input logic [31:0] pos,
                                       input int unsigned lo,
                                       input int unsigned len);
        return (pos >= lo) && (pos < (lo + len));
    endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// -----------------------------------------------------------------------------
// pix_tick_gen
//   Free-running prescaler 0..CLK_DIV-1. oTick is high for the one system
//   clock in which the prescaler sits at CLK_DIV-1, so after reset release
//   the first tick is consumed on the CLK_DIV-th rising edge.
//
// Ports
//   iClk    in   system clock
//   iRst_n  in   asynchronous active-low reset
//   oTick   out  one-clock strobe, once every CLK_DIV clocks
// -----------------------------------------------------------------------------
module pix_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic iClk,
    input  logic iRst_n,
    output logic oTick
);

    // A 1-bit prescaler is kept even for CLK_DIV=1; it then never leaves 0.
    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            presc <= '0;
        end else if (presc == LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Gated by reset: with CLK_DIV=1 the prescaler is always at LAST, yet
    // the strobe must read 0 while reset is held.
    assign oTick = iRst_n && (presc == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   VGA raster timing: pixel/line counters advanced by a prescaled pixel tick,
//   sync/active decode, and a one-pixel output register stage. The pattern
//   modules see (oCountH, oCountV) and answer with iDraw/iColor for that
//   position; the answer is captured on the same tick that advances the
//   counters, so oHS/oVS/oColor trail the counters by exactly one pixel.
//
// Ports
//   iClk         in   system clock, all state on its rising edge
//   iRst_n       in   asynchronous active-low reset
//   oCountH      out  current pixel column
//   oCountV      out  current line
//   oPixTick     out  one-clock strobe per pixel advance
//   oFrameStart  out  one-clock strobe after the counters enter (0,0)
//   iDraw        in   draw flag for (oCountH, oCountV)
//   iColor       in   colour for (oCountH, oCountV)
//   oHS, oVS     out  active-low sync
//   oColor       out  registered, blanked colour
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_TOT      = DEF_H_TOT,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_TOT      = DEF_V_TOT,
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned COLOR_SIZE = DEF_COLOR_SIZE
) (
    input  logic                       iClk,
    input  logic                       iRst_n,
    output logic [$clog2(H_TOT)-1:0]   oCountH,
    output logic [$clog2(V_TOT)-1:0]   oCountV,
    output logic                       oPixTick,
    output logic                       oFrameStart,
    input  logic                       iDraw,
    input  logic [COLOR_SIZE-1:0]      iColor,
    output logic                       oHS,
    output logic                       oVS,
    output logic [COLOR_SIZE-1:0]      oColor
);

    localparam int unsigned HW = $clog2(H_TOT);
    localparam int unsigned VW = $clog2(V_TOT);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);

    // ------------------------------------------------------------------
    // Pixel tick
    // ------------------------------------------------------------------
    logic pix_tick;

    pix_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick_gen (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .oTick  (pix_tick)
    );

    assign oPixTick = pix_tick;

    // ------------------------------------------------------------------
    // Decode of the current (pre-increment) position
    // ------------------------------------------------------------------
    logic        h_last;
    logic        v_last;
    logic [31:0] h_pos;
    logic [31:0] v_pos;
    logic        active;
    logic        hs_win;
    logic        vs_win;

    assign h_last = (oCountH == H_LAST);
    assign v_last = (oCountV == V_LAST);
    assign h_pos  = 32'(oCountH);
    assign v_pos  = 32'(oCountV);

    assign active = (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
    assign hs_win = in_window(h_pos, H_ACTIVE + H_FP, H_SYNC);
    assign vs_win = in_window(v_pos, V_ACTIVE + V_FP, V_SYNC);

    // ------------------------------------------------------------------
    // Counters and frame-start strobe
    // ------------------------------------------------------------------
    // first_tick makes the very first pixel after reset announce a frame,
    // since the counters sit at (0,0) without having wrapped into it.
    logic first_tick;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oCountH     <= '0;
            oCountV     <= '0;
            oFrameStart <= 1'b0;
            first_tick  <= 1'b1;
        end else begin
            oFrameStart <= 1'b0;
            if (pix_tick) begin
                oCountH     <= h_last ? '0 : oCountH + 1'b1;
                if (h_last) begin
                    oCountV <= v_last ? '0 : oCountV + 1'b1;
                end
                oFrameStart <= first_tick | (h_last & v_last);
                first_tick  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage: captures the decode of the position being left, so
    // iDraw/iColor are only looked at in tick clocks.
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oHS    <= 1'b1;
            oVS    <= 1'b1;
            oColor <= '0;
        end else if (pix_tick) begin
            oHS    <= ~hs_win;
            oVS    <= ~vs_win;
            oColor <= (active && iDraw) ? iColor : '0;
        end
    end

endmodule
